// File: rtl/sha256_digest_reader_pkg.sv
// Shared constants, reader state encoding and digest word-select helper for the
// SHA-256 digest readout path.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int DIGEST_W  = 256;
    localparam int IDX_W     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } reader_state_e;

    // Bit offset of word idx inside a packed digest; word 0 (H0) sits at the MSB end.
    function automatic int word_lsb(input int idx, input int num_words, input int word_w);
        return (num_words - 1 - idx) * word_w;
    endfunction

endpackage

// File: rtl/sha256_digest_reader_word_buffer.sv
// Capture register file for one digest: load-all from the packed digest,
// indexed read of a single word.
module sha256_word_buffer #(
    parameter int WORD_W    = sha256_pkg::WORD_W,
    parameter int NUM_WORDS = sha256_pkg::NUM_WORDS,
    parameter int IDX_W     = sha256_pkg::IDX_W
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          load_i,
    input  logic [WORD_W*NUM_WORDS-1:0]   digest_i,
    input  logic [IDX_W-1:0]              rd_idx_i,
    output logic [WORD_W-1:0]             rd_data_o
);
    import sha256_pkg::*;

    logic [WORD_W-1:0] words [NUM_WORDS];

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        logic [WORD_W-1:0] word_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                word_q <= '0;
            end else if (load_i) begin
                word_q <= digest_i[word_lsb(w, NUM_WORDS, WORD_W) +: WORD_W];
            end
        end

        assign words[w] = word_q;
    end

    assign rd_data_o = words[rd_idx_i];

endmodule

// File: rtl/sha256_digest_reader.sv
// Captures the final SHA-256 digest and streams H0..H7 over valid/ready.
// Optional sticky overrun flag: define SHA256_DIGEST_READER_OVERRUN_EN.
module sha256_digest_reader #(
    parameter int WORD_W    = sha256_pkg::WORD_W,
    parameter int NUM_WORDS = sha256_pkg::NUM_WORDS,
    parameter int IDX_W     = sha256_pkg::IDX_W
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          digest_valid_i,
    input  logic [WORD_W*NUM_WORDS-1:0]   digest_i,
    input  logic                          ready_i,
    output logic [WORD_W-1:0]             data_o,
    output logic                          valid_o,
    output logic                          last_o,
    output logic                          busy_o,
    output logic                          done_o
`ifdef SHA256_DIGEST_READER_OVERRUN_EN
    ,
    output logic                          overrun_o
`endif
);
    import sha256_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    reader_state_e     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, last_q, busy_q, done_q;
    logic              handshake, final_hs, capture;

    // A new digest is accepted when idle, or on the H7 handshake for back-to-back streams.
    always_comb begin
        handshake = (state_q == SEND) && ready_i;
        final_hs  = handshake && (idx_q == LAST_IDX);
        capture   = digest_valid_i && ((state_q == IDLE) || final_hs);
        state_d   = state_q;
        idx_d     = idx_q;
        case (state_q)
            IDLE: begin
                if (digest_valid_i) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (final_hs) begin
                    idx_d   = '0;
                    state_d = digest_valid_i ? SEND : IDLE;
                end else if (handshake) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

`ifdef SHA256_DIGEST_READER_OVERRUN_EN
    logic overrun_q;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SHA256_DIGEST_READER_OVERRUN_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= (state_d == SEND);
            busy_q    <= (state_d == SEND);
            last_q    <= (state_d == SEND) && (idx_d == LAST_IDX);
            done_q    <= final_hs;
`ifdef SHA256_DIGEST_READER_OVERRUN_EN
            overrun_q <= overrun_q | (digest_valid_i && (state_q == SEND) && !final_hs);
`endif
        end
    end

    sha256_word_buffer #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_buffer (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .load_i    (capture),
        .digest_i  (digest_i),
        .rd_idx_i  (idx_q),
        .rd_data_o (data_o)
    );

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
`ifdef SHA256_DIGEST_READER_OVERRUN_EN
    assign overrun_o = overrun_q;
`endif

endmodule
